// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder.
//   WIDTH / N / PE_LAT : default word width, array dimension, PE hop latency
//   vec_t              : one activation/bias vector, element i -> row/column i
//   feeder_state_t     : feeder FSM encoding
//   flush_len()        : cycles from the last accept until the last result
package systolic_pkg;

   localparam int WIDTH  = 16;
   localparam int N      = 4;
   localparam int PE_LAT = 1;

   typedef logic signed [N-1:0][WIDTH-1:0] vec_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH
   } feeder_state_t;

   function automatic int flush_len(input int n, input int pe_lat);
      return n + n * pe_lat;
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Stream / array bundle between the activation source, the feeder and the
// result collector.
//   s_valid, s_ready, s_data, s_last : activation vector handshake
//   bias_load, bias_in               : per-column bias update
//   in_left, in_up                   : skewed row data / column bias to the array
//   res_valid, tile_done             : result lane mask and end-of-tile pulse
// Modports: slave = feeder, master = source/collector side.
interface systolic_feeder_if #(
   parameter int WIDTH = systolic_pkg::WIDTH,
   parameter int N     = systolic_pkg::N
);

   logic                           s_valid;
   logic                           s_ready;
   logic signed [N-1:0][WIDTH-1:0] s_data;
   logic                           s_last;
   logic                           bias_load;
   logic signed [N-1:0][WIDTH-1:0] bias_in;
   logic signed [N-1:0][WIDTH-1:0] in_left;
   logic signed [N-1:0][WIDTH-1:0] in_up;
   logic [N-1:0]                   res_valid;
   logic                           tile_done;

   modport slave (
      input  s_valid, s_data, s_last, bias_load, bias_in,
      output s_ready, in_left, in_up, res_valid, tile_done
   );

   modport master (
      output s_valid, s_data, s_last, bias_load, bias_in,
      input  s_ready, in_left, in_up, res_valid, tile_done
   );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth {valid, data} delay line used for one skew lane.
//   clk, rst  : clock, synchronous active-high reset (clears every stage)
//   i_valid   : valid bit entering stage 0
//   i_data    : data word entering stage 0
//   o_valid   : valid bit after DEPTH cycles
//   o_data    : data word after DEPTH cycles
module skew_line #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic [DEPTH-1:0]            r_valid;
   logic [DEPTH-1:0][WIDTH-1:0] r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_data[0]  <= i_data;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_data[k]  <= r_data[k-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the NxN systolic PE array. Accepts activation vectors on a
// valid/ready stream, skews them diagonally onto in_left, skews the per-column
// bias onto in_up, predicts which out_right lanes carry results (res_valid) and
// pulses tile_done when the last result of a tile reaches out_right.
//   clk, rst : clock, synchronous active-high reset (discards any tile in flight)
//   bus      : systolic_feeder_if slave modport (stream, bias, array-side lanes)
module systolic_feeder #(
   parameter int WIDTH  = systolic_pkg::WIDTH,
   parameter int N      = systolic_pkg::N,
   parameter int PE_LAT = systolic_pkg::PE_LAT
) (
   input  logic              clk,
   input  logic              rst,
   systolic_feeder_if.slave  bus
);

   import systolic_pkg::*;

   localparam int            FLUSH_LEN = flush_len(N, PE_LAT);
   localparam int            TAIL      = N * PE_LAT;
   localparam int            CW        = $clog2(FLUSH_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT  = CW'(FLUSH_LEN - 1);

   feeder_state_t             r_state;
   feeder_state_t             w_state_nxt;
   logic [CW-1:0]             r_cnt;
   logic [CW-1:0]             w_cnt_nxt;
   logic                      w_ready_st;
   logic                      w_ready;
   logic                      w_accept;
   logic                      w_bias_we;
   logic                      w_tile_done;

   logic [N-1:0][WIDTH-1:0]   r_bias;
   logic [N-1:0][WIDTH-1:0]   w_bias_eff;
   logic [N-1:0][WIDTH-1:0]   w_left_in;
   logic [N-1:0][WIDTH-1:0]   w_up_in;
   logic [N-1:0][WIDTH-1:0]   w_left_d;
   logic [N-1:0][WIDTH-1:0]   w_up_d;
   logic [N-1:0][WIDTH-1:0]   w_in_left;
   logic [N-1:0][WIDTH-1:0]   w_in_up;
   logic [N-1:0]              w_left_v;
   logic [N-1:0]              w_up_v;
   logic [N-1:0]              w_res_valid;
   logic [N-1:0][TAIL-1:0]    r_tail;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_ready_st  = 1'b0;
      w_bias_we   = 1'b0;
      w_tile_done = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready_st = 1'b1;
            w_bias_we  = bus.bias_load;
            if (bus.s_valid) begin
               w_state_nxt = bus.s_last ? FLUSH : STREAM;
            end
         end
         STREAM: begin
            w_ready_st = 1'b1;
            if (bus.s_valid && bus.s_last) begin
               w_state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == LAST_CNT) begin
               w_tile_done = 1'b1;
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Gating with rst keeps s_ready low for the whole reset window, including
   // the cycles where the state register already reads IDLE.
   assign w_ready  = w_ready_st & ~rst;
   assign w_accept = bus.s_valid & w_ready;

   // ---------------- bias ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bias <= '0;
      end else if (w_bias_we) begin
         r_bias <= bus.bias_in;
      end
   end

   // A bias load coinciding with an accept in IDLE applies to that vector.
   assign w_bias_eff = w_bias_we ? bus.bias_in : r_bias;

   // ---------------- skew lanes ----------------
   always_comb begin
      w_left_in = '0;
      w_up_in   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_accept) begin
            w_left_in[i] = bus.s_data[i];
            w_up_in[i]   = w_bias_eff[i];
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_line #(
         .WIDTH (WIDTH),
         .DEPTH (i + 1)
      ) u_left (
         .clk     (clk),
         .rst     (rst),
         .i_valid (w_accept),
         .i_data  (w_left_in[i]),
         .o_valid (w_left_v[i]),
         .o_data  (w_left_d[i])
      );

      skew_line #(
         .WIDTH (WIDTH),
         .DEPTH (i * PE_LAT + 1)
      ) u_up (
         .clk     (clk),
         .rst     (rst),
         .i_valid (w_accept),
         .i_data  (w_up_in[i]),
         .o_valid (w_up_v[i]),
         .o_data  (w_up_d[i])
      );
   end

   // Result tail: lane valid continues through the N horizontal PE hops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tail <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            r_tail[i][0] <= w_left_v[i];
            for (int unsigned k = 1; k < TAIL; k++) begin
               r_tail[i][k] <= r_tail[i][k-1];
            end
         end
      end
   end

   always_comb begin
      w_in_left   = '0;
      w_in_up     = '0;
      w_res_valid = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_in_left[i]   = w_left_v[i] ? w_left_d[i] : '0;
         w_in_up[i]     = w_up_v[i]   ? w_up_d[i]   : '0;
         w_res_valid[i] = r_tail[i][TAIL-1];
      end
   end

   assign bus.s_ready   = w_ready;
   assign bus.in_left   = w_in_left;
   assign bus.in_up     = w_in_up;
   assign bus.res_valid = w_res_valid;
   assign bus.tile_done = w_tile_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, PE_LAT=1, WIDTH=16). Stimulus pushes
// expected lane events into per-lane queues; a monitor compares every lane each
// cycle, expecting zero wherever no event is due.
module tb_systolic_feeder;

   import systolic_pkg::*;

   localparam int NN = 4;
   localparam int PL = 1;
   localparam int FL = NN + NN * PL;

   typedef struct {
      int         c;
      logic [15:0] v;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   busy_lo = 0;
   int   busy_hi = -1;
   int   acc_a, acc_b;

   vec_t bias_model;
   ev_t  q_left [NN][$];
   ev_t  q_up   [NN][$];
   int   q_rv   [NN][$];
   int   q_td   [$];

   logic [15:0] mon_ev;
   logic        mon_bv;

   always #5 clk = ~clk;

   systolic_feeder_if #(.WIDTH(16), .N(NN)) bus ();

   systolic_feeder #(
      .WIDTH  (16),
      .N      (NN),
      .PE_LAT (PL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic vec_t mk(input int a, input int b, input int c, input int d);
      vec_t r;
      r[0] = 16'(a);
      r[1] = 16'(b);
      r[2] = 16'(c);
      r[3] = 16'(d);
      return r;
   endfunction

   task automatic push(input vec_t d, input bit last, input int e);
      for (int i = 0; i < NN; i++) begin
         q_left[i].push_back(ev_t'{c: e + 1 + i, v: d[i]});
         q_up[i].push_back(ev_t'{c: e + 1 + i * PL, v: bias_model[i]});
         q_rv[i].push_back(e + 1 + i + NN * PL);
      end
      if (last) begin
         q_td.push_back(e + NN + NN * PL);
         busy_lo = e + 1;
         busy_hi = e + FL;
      end
   endtask

   task automatic clear_sb();
      for (int i = 0; i < NN; i++) begin
         q_left[i].delete();
         q_up[i].delete();
         q_rv[i].delete();
      end
      q_td.delete();
      busy_lo = 0;
      busy_hi = -1;
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input vec_t d, input bit last, output int acc);
      int waited = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      #1;
      while (!bus.s_ready && waited < 64) begin
         @(negedge clk);
         #1;
         waited++;
      end
      acc = cyc;
      check("accept_ready", bus.s_ready, 1);
      if (bus.s_ready) push(d, last, cyc);
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = '0;
   endtask

   task automatic load_bias(input vec_t b, input bit takes);
      bus.bias_load = 1'b1;
      bus.bias_in   = b;
      if (takes) bias_model = b;
      @(negedge clk);
      bus.bias_load = 1'b0;
   endtask

   task automatic drain();
      repeat (FL + NN + 2) @(negedge clk);
   endtask

   // Monitor: one sample per cycle, 1 time unit after the rising edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (mon_en) begin
         for (int i = 0; i < NN; i++) begin
            mon_ev = '0;
            if (q_left[i].size() > 0 && q_left[i][0].c == cyc) begin
               mon_ev = q_left[i][0].v;
               void'(q_left[i].pop_front());
            end
            check($sformatf("in_left[%0d]@%0d", i, cyc), bus.in_left[i], mon_ev);
            mon_ev = '0;
            if (q_up[i].size() > 0 && q_up[i][0].c == cyc) begin
               mon_ev = q_up[i][0].v;
               void'(q_up[i].pop_front());
            end
            check($sformatf("in_up[%0d]@%0d", i, cyc), bus.in_up[i], mon_ev);
            mon_bv = 1'b0;
            if (q_rv[i].size() > 0 && q_rv[i][0] == cyc) begin
               mon_bv = 1'b1;
               void'(q_rv[i].pop_front());
            end
            check($sformatf("res_valid[%0d]@%0d", i, cyc), bus.res_valid[i], mon_bv);
         end
         mon_bv = 1'b0;
         if (q_td.size() > 0 && q_td[0] == cyc) begin
            mon_bv = 1'b1;
            void'(q_td.pop_front());
         end
         check($sformatf("tile_done@%0d", cyc), bus.tile_done, mon_bv);
         check($sformatf("s_ready@%0d", cyc), bus.s_ready,
               !rst && !(cyc >= busy_lo && cyc <= busy_hi));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      bus.s_valid   = 1'b0;
      bus.s_last    = 1'b0;
      bus.s_data    = '0;
      bus.bias_load = 1'b0;
      bus.bias_in   = '0;
      bias_model    = '0;

      // 1: reset, three edges with rst high
      @(negedge clk);
      mon_en = 1'b1;
      check("rst_ready", bus.s_ready, 0);
      @(negedge clk);
      @(negedge clk);
      check("rst_ready_last", bus.s_ready, 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", bus.s_ready, 1);
      @(negedge clk);

      // 2: single-vector tile
      send(mk(1, 2, 3, 4), 1'b1, acc_a);
      drain();

      // 3: bias loaded in IDLE, ignored in STREAM
      load_bias(mk(10, 20, 30, 40), 1'b1);
      send(mk(-5, 6, 7, 8), 1'b0, acc_a);
      load_bias(mk(99, 98, 97, 96), 1'b0);
      send(mk(11, 12, 13, 14), 1'b1, acc_a);
      drain();

      // 4: burst A,B, bubble, C+last; bias loaded together with A's accept
      bus.bias_load = 1'b1;
      bus.bias_in   = mk(1, -1, 2, -2);
      bias_model    = mk(1, -1, 2, -2);
      send(mk(16'h0A0, 16'h0A1, 16'h0A2, 16'h0A3), 1'b0, acc_a);
      bus.bias_load = 1'b0;
      send(mk(16'h0B0, 16'h0B1, 16'h0B2, 16'h0B3), 1'b0, acc_b);
      check("burst_b_follows_a", acc_b, acc_a + 1);
      @(negedge clk);
      send(mk(16'h0C0, 16'h0C1, -3, 16'h0C3), 1'b1, acc_a);
      check("bubble_c_after_gap", acc_a, acc_b + 2);
      drain();

      // 5: reset two cycles after the third vector of an unfinished tile
      send(mk(21, 22, 23, 24), 1'b0, acc_a);
      send(mk(31, 32, 33, 34), 1'b0, acc_a);
      send(mk(41, 42, 43, 44), 1'b0, acc_a);
      @(negedge clk);
      rst = 1'b1;
      clear_sb();
      @(negedge clk);
      check("midrst_ready", bus.s_ready, 0);
      check("midrst_left3", bus.in_left[3], 0);
      rst = 1'b0;
      bias_model = '0;
      @(negedge clk);
      send(mk(51, 52, 53, 54), 1'b1, acc_a);
      drain();

      // 6: source holds s_valid with s_last through FLUSH
      send(mk(61, 62, 63, 64), 1'b1, acc_a);
      send(mk(71, 72, 73, 74), 1'b1, acc_b);
      check("held_accept_cycle", acc_b, acc_a + FL + 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
